data_ram: RTL and testbench

DATA_RAM -- requirements
Module: data_ram

---
 rtl/data_ram.sv | 217 +++++++++++++++++++++
 tb/tb_data_ram.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/data_ram.sv
// Byte-addressable RV32I data memory: 32-bit word array with byte/half/word
// loads and stores, access-fault detection and a one-cycle load response.
module data_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter bit INIT_ZERO   = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req,
    input  logic        we,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        err
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [31:0] INIT_WORD = INIT_ZERO ? 32'h0000_0000 : 32'hxxxx_xxxx;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    logic [31:0]   mem_r [DEPTH_WORDS] = '{default: INIT_WORD};

    logic [AW-1:0] idx_s;
    logic          out_of_range_s;
    logic          misalign_s;
    logic          load_ok_s;
    logic          store_ok_s;
    logic          fault_s;
    logic [3:0]    be_s;
    logic [31:0]   wdata_lane_s;
    logic          wr_en_s;
    logic          ld_en_s;

    logic [31:0]   rd_word_r;
    logic [1:0]    off_r;
    logic [2:0]    f3_r;
    logic          rvalid_r;
    logic          err_r;
    logic [31:0]   rdata_last_r;

    logic [7:0]    byte_s;
    logic [15:0]   half_s;
    logic [31:0]   ext_s;
    logic [31:0]   rdata_s;

    assign idx_s          = addr[AW+1:2];
    assign out_of_range_s = (addr >> (AW + 2)) != 32'd0;

    // Decode width code into legality, byte enables and lane-steered store data.
    always_comb begin
        misalign_s   = 1'b0;
        load_ok_s    = 1'b0;
        store_ok_s   = 1'b0;
        be_s         = 4'b0000;
        wdata_lane_s = wdata;
        case (funct3)
            F3_B: begin
                load_ok_s    = 1'b1;
                store_ok_s   = 1'b1;
                be_s         = 4'b0001 << addr[1:0];
                wdata_lane_s = {4{wdata[7:0]}};
            end
            F3_H: begin
                misalign_s   = addr[0];
                load_ok_s    = 1'b1;
                store_ok_s   = 1'b1;
                be_s         = addr[1] ? 4'b1100 : 4'b0011;
                wdata_lane_s = {2{wdata[15:0]}};
            end
            F3_W: begin
                misalign_s   = addr[1:0] != 2'b00;
                load_ok_s    = 1'b1;
                store_ok_s   = 1'b1;
                be_s         = 4'b1111;
            end
            F3_BU: begin
                load_ok_s    = 1'b1;
            end
            F3_HU: begin
                misalign_s   = addr[0];
                load_ok_s    = 1'b1;
            end
            default: begin
                load_ok_s    = 1'b0;
                store_ok_s   = 1'b0;
            end
        endcase
    end

    // Fault qualification and array access enables for the current request.
    always_comb begin
        if (we) begin
            fault_s = out_of_range_s | misalign_s | ~store_ok_s;
        end else begin
            fault_s = out_of_range_s | misalign_s | ~load_ok_s;
        end
        wr_en_s = req & we & ~fault_s & ~rst;
        ld_en_s = req & ~we;
    end

    // Array port: masked byte-lane write and synchronous word read; not reset.
    always_ff @(posedge clk) begin
        if (wr_en_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_r[idx_s][8*i +: 8] <= wdata_lane_s[8*i +: 8];
                end
            end
        end
        if (ld_en_s) begin
            rd_word_r <= mem_r[idx_s];
        end
    end

    // Response pipeline: load attributes, response strobes and held read data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            off_r        <= 2'b00;
            f3_r         <= 3'b000;
            rvalid_r     <= 1'b0;
            err_r        <= 1'b0;
            rdata_last_r <= 32'h0000_0000;
        end else begin
            rvalid_r <= ld_en_s;
            err_r    <= req & fault_s;
            if (ld_en_s) begin
                off_r <= addr[1:0];
                f3_r  <= funct3;
            end
            if (rvalid_r) begin
                rdata_last_r <= rdata_s;
            end
        end
    end

    // Right-align and extend the registered word according to the load width.
    always_comb begin
        case (off_r)
            2'd0:    byte_s = rd_word_r[7:0];
            2'd1:    byte_s = rd_word_r[15:8];
            2'd2:    byte_s = rd_word_r[23:16];
            2'd3:    byte_s = rd_word_r[31:24];
            default: byte_s = 8'h00;
        endcase
        if (off_r[1]) begin
            half_s = rd_word_r[31:16];
        end else begin
            half_s = rd_word_r[15:0];
        end
        case (f3_r)
            F3_B:    ext_s = {{24{byte_s[7]}}, byte_s};
            F3_BU:   ext_s = {24'h00_0000, byte_s};
            F3_H:    ext_s = {{16{half_s[15]}}, half_s};
            F3_HU:   ext_s = {16'h0000, half_s};
            F3_W:    ext_s = rd_word_r;
            default: ext_s = 32'h0000_0000;
        endcase
    end

    // A faulted load returns zero; between responses the last value is held.
    always_comb begin
        if (rvalid_r && err_r) begin
            rdata_s = 32'h0000_0000;
        end else if (rvalid_r) begin
            rdata_s = ext_s;
        end else begin
            rdata_s = rdata_last_r;
        end
    end

    assign rdata  = rdata_s;
    assign rvalid = rvalid_r;
    assign err    = err_r;

    data_ram_chk u_chk (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .rvalid (rvalid_r),
        .err    (err_r),
        .rdata  (rdata_s)
    );

endmodule

// Protocol properties of the data_ram response interface.
module data_ram_chk (
    input logic        clk,
    input logic        rst,
    input logic        req,
    input logic        we,
    input logic        rvalid,
    input logic        err,
    input logic [31:0] rdata
);

    // Responses only ever follow a request; stores never raise rvalid.
    always @(posedge clk) begin
        if (!rst) begin
            assert (!(rvalid || err) || $past(req))
                else $error("data_ram_chk: response without request");
            assert (!rvalid || !$past(we))
                else $error("data_ram_chk: rvalid after store");
            assert (!(rvalid && err) || rdata == 32'h0000_0000)
                else $error("data_ram_chk: faulted load with nonzero rdata");
        end
    end

endmodule

// File: tb/tb_data_ram.sv
// Directed self-checking bench for data_ram: loads/stores of every width,
// faults, back-to-back traffic and asynchronous reset.
module tb_data_ram;

    localparam logic [2:0] B  = 3'b000;
    localparam logic [2:0] H  = 3'b001;
    localparam logic [2:0] W  = 3'b010;
    localparam logic [2:0] BU = 3'b100;
    localparam logic [2:0] HU = 3'b101;

    logic        clk;
    logic        rst;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        rvalid;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;
    int n_valid  = 0;

    logic [2:0]  ld_f3   [10] = '{W, B, BU, B, H, HU, W, W, HU, B};
    logic [31:0] ld_addr [10] = '{32'h30, 32'h30, 32'h31, 32'h31, 32'h32,
                                  32'h32, 32'h10, 32'h20, 32'h20, 32'h33};
    logic [31:0] ld_exp  [10] = '{32'hCAFE_F077, 32'h0000_0077, 32'h0000_00F0,
                                  32'hFFFF_FFF0, 32'hFFFF_CAFE, 32'h0000_CAFE,
                                  32'hAA65_4321, 32'hBEEF_1111, 32'h0000_1111,
                                  32'hFFFF_FFCA};

    data_ram #(.DEPTH_WORDS(64), .INIT_ZERO(1'b1)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .funct3 (funct3),
        .addr   (addr),
        .wdata  (wdata),
        .rdata  (rdata),
        .rvalid (rvalid),
        .err    (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rsp(input string tag, input logic v, input logic e, input logic [31:0] d);
        chk({tag, ".rvalid"}, {31'd0, rvalid}, {31'd0, v});
        chk({tag, ".err"},    {31'd0, err},    {31'd0, e});
        chk({tag, ".rdata"},  rdata, d);
    endtask

    task automatic issue(input logic w, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] d);
        @(negedge clk);
        req    = 1'b1;
        we     = w;
        funct3 = f;
        addr   = a;
        wdata  = d;
    endtask

    task automatic idle();
        @(negedge clk);
        req = 1'b0;
        we  = 1'b0;
    endtask

    initial begin
        rst    = 1'b1;
        req    = 1'b0;
        we     = 1'b0;
        funct3 = 3'b000;
        addr   = 32'h0;
        wdata  = 32'h0;
        @(negedge clk);
        @(negedge clk);
        rsp("reset", 1'b0, 1'b0, 32'h0);
        rst = 1'b0;

        issue(1'b1, W, 32'h10, 32'h8765_4321);
        issue(1'b0, W, 32'h10, 32'h0);          rsp("sw10", 1'b0, 1'b0, 32'h0);
        issue(1'b1, B, 32'h13, 32'h1234_56AA);  rsp("lw10", 1'b1, 1'b0, 32'h8765_4321);
        issue(1'b0, B, 32'h13, 32'h0);          rsp("sb13", 1'b0, 1'b0, 32'h8765_4321);
        issue(1'b0, BU, 32'h13, 32'h0);         rsp("lb13", 1'b1, 1'b0, 32'hFFFF_FFAA);
        issue(1'b0, W, 32'h10, 32'h0);          rsp("lbu13", 1'b1, 1'b0, 32'h0000_00AA);
        issue(1'b0, B, 32'h12, 32'h0);          rsp("lw10b", 1'b1, 1'b0, 32'hAA65_4321);
        issue(1'b0, H, 32'h12, 32'h0);          rsp("lb12", 1'b1, 1'b0, 32'h0000_0065);
        issue(1'b1, W, 32'h20, 32'h1111_1111);  rsp("lh12", 1'b1, 1'b0, 32'hFFFF_AA65);
        issue(1'b1, H, 32'h22, 32'hDEAD_BEEF);  rsp("sw20", 1'b0, 1'b0, 32'hFFFF_AA65);
        issue(1'b0, H, 32'h22, 32'h0);          rsp("sh22", 1'b0, 1'b0, 32'hFFFF_AA65);
        issue(1'b0, HU, 32'h22, 32'h0);         rsp("lh22", 1'b1, 1'b0, 32'hFFFF_BEEF);
        issue(1'b0, W, 32'h20, 32'h0);          rsp("lhu22", 1'b1, 1'b0, 32'h0000_BEEF);
        issue(1'b0, HU, 32'h20, 32'h0);         rsp("lw20", 1'b1, 1'b0, 32'hBEEF_1111);
        issue(1'b0, W, 32'h11, 32'h0);          rsp("lhu20", 1'b1, 1'b0, 32'h0000_1111);
        issue(1'b1, H, 32'h21, 32'h0000_5555);  rsp("lw11_fault", 1'b1, 1'b1, 32'h0);
        issue(1'b0, W, 32'h20, 32'h0);          rsp("sh21_fault", 1'b0, 1'b1, 32'h0);
        issue(1'b0, W, 32'h100, 32'h0);         rsp("lw20_kept", 1'b1, 1'b0, 32'hBEEF_1111);
        issue(1'b0, 3'b011, 32'h10, 32'h0);     rsp("lw100_fault", 1'b1, 1'b1, 32'h0);
        issue(1'b1, BU, 32'h10, 32'hFFFF_FFFF); rsp("ld011_fault", 1'b1, 1'b1, 32'h0);
        issue(1'b1, W, 32'hFC, 32'h0BAD_CAFE);  rsp("st100_fault", 1'b0, 1'b1, 32'h0);
        issue(1'b0, W, 32'hFC, 32'h0);          rsp("swFC", 1'b0, 1'b0, 32'h0);
        issue(1'b0, W, 32'h10, 32'h0);          rsp("lwFC", 1'b1, 1'b0, 32'h0BAD_CAFE);
        idle();                                 rsp("lw10c", 1'b1, 1'b0, 32'hAA65_4321);
        idle();                                 rsp("idle_hold", 1'b0, 1'b0, 32'hAA65_4321);

        // Store, then store-to-same-word, then ten back-to-back loads.
        issue(1'b1, W, 32'h30, 32'hCAFE_F00D);
        issue(1'b1, B, 32'h30, 32'h0000_0077);  rsp("sw30", 1'b0, 1'b0, 32'hAA65_4321);
        for (int i = 0; i < 10; i++) begin
            issue(1'b0, ld_f3[i], ld_addr[i], 32'h0);
            if (i == 0) begin
                rsp("sb30", 1'b0, 1'b0, 32'hAA65_4321);
            end else begin
                if (rvalid) n_valid++;
                rsp($sformatf("b2b%0d", i - 1), 1'b1, 1'b0, ld_exp[i-1]);
            end
        end
        idle();
        if (rvalid) n_valid++;
        rsp("b2b9", 1'b1, 1'b0, ld_exp[9]);
        chk("b2b_valid_count", n_valid, 32'd10);

        // Asynchronous reset while a load response is on the outputs.
        issue(1'b0, W, 32'h10, 32'h0);
        @(posedge clk);
        #1;
        rsp("pre_rst", 1'b1, 1'b0, 32'hAA65_4321);
        #1 rst = 1'b1;
        #1;
        rsp("async_rst", 1'b0, 1'b0, 32'h0);
        issue(1'b1, W, 32'h20, 32'hFFFF_FFFF);
        @(posedge clk);
        #1;
        rsp("st_in_rst", 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        rst    = 1'b0;
        we     = 1'b0;
        funct3 = W;
        addr   = 32'h20;
        issue(1'b0, W, 32'h10, 32'h0);          rsp("post_rst_lw20", 1'b1, 1'b0, 32'hBEEF_1111);
        idle();                                 rsp("post_rst_lw10", 1'b1, 1'b0, 32'hAA65_4321);
        idle();                                 rsp("post_rst_idle", 1'b0, 1'b0, 32'hAA65_4321);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
